// File: rtl/johnson_decoder.sv
// ----------------------------------------------------------------------------
// johnson_decoder
//
// Receive-side companion to a low-power Johnson counter. Each enabled cycle
// the N-bit Johnson state on q_in is decoded to a binary phase index and a
// one-hot phase vector, checked for illegal codes and non-adjacent steps, and
// fed to a lock state machine (UNLOCKED -> ACQUIRE -> LOCKED). Errors are
// counted in a saturating counter. Downstream logic should trust the phase
// only while locked is high.
//
// Ports:
//   clk           in   1      rising-edge clock
//   reset         in   1      asynchronous, active-high reset
//   sample_en     in   1      capture and evaluate q_in this cycle
//   q_in          in   N      Johnson state, bit 0 fed by the inverted MSB
//   clear_err     in   1      synchronous clear of err_count (wins over +1)
//   phase         out  PW     decoded phase index, 0..2N-1
//   phase_onehot  out  2N     one-hot of phase, zero until a legal code seen
//   code_valid    out  1      last sampled code was legal
//   step_err      out  1      one-cycle pulse on illegal code / illegal jump
//   locked        out  1      lock state machine is in LOCKED
//   err_count     out  ERR_W  saturating error count
//
// All outputs are registered; results of a sample taken on edge t are visible
// after edge t. q_in is assumed already synchronous to clk.
// ----------------------------------------------------------------------------
module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    localparam int PW      = $clog2(2 * N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_en,
    input  logic [N-1:0]       q_in,
    input  logic               clear_err,
    output logic [PW-1:0]      phase,
    output logic [2*N-1:0]     phase_onehot,
    output logic               code_valid,
    output logic               step_err,
    output logic               locked,
    output logic [ERR_W-1:0]   err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    // Legal Johnson code for phase k: the first N+1 phases fill ones from
    // bit 0 upward, the remaining phases clear ones from bit 0 upward.
    function automatic logic [N-1:0] f_code(input int k);
        logic [N-1:0] v;
        for (int b = 0; b < N; b++) begin
            v[b] = (k <= N) ? (b < k) : (b >= (k - N));
        end
        return v;
    endfunction

    logic [1:0]         r_state;
    logic [GW-1:0]      r_good_cnt;
    logic [PW-1:0]      r_phase;
    logic [2*N-1:0]     r_onehot;
    logic               r_code_valid;
    logic               r_step_err;
    logic               r_locked;
    logic [ERR_W-1:0]   r_err_count;

    logic               w_legal;
    logic [PW-1:0]      w_new_phase;
    logic [2*N-1:0]     w_new_onehot;
    logic [PW-1:0]      w_next_ref;
    logic               w_adjacent;
    logic               w_hold;
    logic               w_err;
    logic [1:0]         w_state_nxt;
    logic [GW-1:0]      w_good_nxt;

    // Decode q_in against every legal code. r_phase doubles as the reference
    // phase, since it always holds the last legal phase seen.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_legal      = 1'b0;
        w_new_phase  = '0;
        w_new_onehot = '0;
        for (int k = 0; k < 2 * N; k++) begin
            if (q_in == f_code(k)) begin
                w_legal     = 1'b1;
                w_new_phase = PW'(k);
            end
        end
        w_new_onehot[w_new_phase] = 1'b1;
    end

    // Wrap explicitly: 2N need not be a power of two.
    assign w_next_ref = (r_phase == PW'(2 * N - 1)) ? '0 : r_phase + 1'b1;
    assign w_adjacent = (w_new_phase == w_next_ref);
    assign w_hold     = (w_new_phase == r_phase);

    // Lock state machine and error detection.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_err       = 1'b0;
        if (sample_en) begin
            if (!w_legal) begin
                w_err       = 1'b1;
                w_state_nxt = ST_UNLOCKED;
                w_good_nxt  = '0;
            end else begin
                case (r_state)
                    ST_UNLOCKED: begin
                        w_state_nxt = ST_ACQUIRE;
                        w_good_nxt  = '0;
                    end
                    ST_ACQUIRE: begin
                        if (w_adjacent) begin
                            w_good_nxt = r_good_cnt + 1'b1;
                            if (r_good_cnt == GW'(LOCK_CNT - 1)) begin
                                w_state_nxt = ST_LOCKED;
                            end
                        end else if (!w_hold) begin
                            w_err      = 1'b1;
                            w_good_nxt = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_adjacent && !w_hold) begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_ACQUIRE;
                            w_good_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_UNLOCKED;
                        w_good_nxt  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_UNLOCKED;
            r_good_cnt   <= '0;
            r_phase      <= '0;
            r_onehot     <= '0;
            r_code_valid <= 1'b0;
            r_step_err   <= 1'b0;
            r_locked     <= 1'b0;
            r_err_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_locked   <= (w_state_nxt == ST_LOCKED);
            r_step_err <= w_err;
            if (sample_en) begin
                r_code_valid <= w_legal;
                if (w_legal) begin
                    r_phase  <= w_new_phase;
                    r_onehot <= w_new_onehot;
                end
            end
            if (clear_err) begin
                r_err_count <= '0;
            end else if (w_err && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign phase        = r_phase;
    assign phase_onehot = r_onehot;
    assign code_valid   = r_code_valid;
    assign step_err     = r_step_err;
    assign locked       = r_locked;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// ----------------------------------------------------------------------------
// tb_johnson_decoder
//
// Scoreboard bench for johnson_decoder. Two instances share the stimulus: the
// default configuration (ERR_W=8) and a narrow-counter one (ERR_W=2) used for
// saturation. The reference model decodes codes by looking them up in a table
// built by clocking an ideal Johnson shift register, and tracks lock status
// with plain integer bookkeeping. The driver pushes expected results into a
// queue; the monitor pops and compares one entry after each rising edge.
// ----------------------------------------------------------------------------
module tb_johnson_decoder;

    localparam int N     = 4;
    localparam int TWO_N = 2 * N;
    localparam int LOCK  = 3;

    typedef struct {
        logic [2:0] phase;
        logic [7:0] onehot;
        logic       code_valid;
        logic       step_err;
        logic       locked;
        logic [7:0] err_count;
        logic [1:0] err_small;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic [3:0] q_in = '0;
    logic       clear_err = 1'b0;

    logic [2:0] phase;
    logic [7:0] phase_onehot;
    logic       code_valid, step_err, locked;
    logic [7:0] err_count;

    logic [2:0] s_phase;
    logic [7:0] s_onehot;
    logic       s_code_valid, s_step_err, s_locked;
    logic [1:0] s_err_count;

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .q_in(q_in),
        .clear_err(clear_err), .phase(phase), .phase_onehot(phase_onehot),
        .code_valid(code_valid), .step_err(step_err), .locked(locked),
        .err_count(err_count)
    );

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK), .ERR_W(2)) u_dut_small (
        .clk(clk), .reset(reset), .sample_en(sample_en), .q_in(q_in),
        .clear_err(clear_err), .phase(s_phase), .phase_onehot(s_onehot),
        .code_valid(s_code_valid), .step_err(s_step_err), .locked(s_locked),
        .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];

    // Reference model state.
    logic [3:0] seq [TWO_N];
    int m_mode;      // 0 unlocked, 1 acquiring, 2 locked
    int m_good;
    int m_phase;
    bit m_seen;
    bit m_valid;
    bit m_err;
    int m_errs;
    int m_errs_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_phase = 0; m_seen = 0;
        m_valid = 0; m_err = 0; m_errs = 0; m_errs_s = 0;
    endtask

    function automatic int lookup(input logic [3:0] q);
        for (int k = 0; k < TWO_N; k++) if (seq[k] == q) return k;
        return -1;
    endfunction

    task automatic model_step(input bit en, input logic [3:0] q, input bit clr);
        int idx;
        bit adj, hold;
        exp_t e;
        m_err = 0;
        if (en) begin
            idx = lookup(q);
            if (idx < 0) begin
                m_valid = 0; m_err = 1; m_mode = 0; m_good = 0;
            end else begin
                m_valid = 1;
                adj  = (idx == (m_phase + 1) % TWO_N);
                hold = (idx == m_phase);
                if (m_mode == 0) begin
                    m_mode = 1; m_good = 0;
                end else if (m_mode == 1) begin
                    if (adj) begin
                        m_good++;
                        if (m_good == LOCK) m_mode = 2;
                    end else if (!hold) begin
                        m_err = 1; m_good = 0;
                    end
                end else if (!adj && !hold) begin
                    m_err = 1; m_mode = 1; m_good = 0;
                end
                m_phase = idx;
                m_seen  = 1;
            end
        end
        if (clr) begin
            m_errs = 0; m_errs_s = 0;
        end else if (m_err) begin
            if (m_errs < 255) m_errs++;
            if (m_errs_s < 3) m_errs_s++;
        end
        e.phase      = 3'(m_phase);
        e.onehot     = m_seen ? 8'(1 << m_phase) : 8'h00;
        e.code_valid = m_valid;
        e.step_err   = m_err;
        e.locked     = (m_mode == 2);
        e.err_count  = 8'(m_errs);
        e.err_small  = 2'(m_errs_s);
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit en, input logic [3:0] q, input bit clr);
        @(negedge clk);
        sample_en = en;
        q_in      = q;
        clear_err = clr;
        model_step(en, q, clr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},  32'(phase), 0);
        check({tag, "_onehot"}, 32'(phase_onehot), 0);
        check({tag, "_valid"},  32'(code_valid), 0);
        check({tag, "_steperr"}, 32'(step_err), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_errcnt"}, 32'(err_count), 0);
        check({tag, "_errcnt_small"}, 32'(s_err_count), 0);
    endtask

    // Monitor: every rising edge presents a result; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("phase",        32'(phase),        32'(e.phase));
                check("phase_onehot", 32'(phase_onehot), 32'(e.onehot));
                check("code_valid",   32'(code_valid),   32'(e.code_valid));
                check("step_err",     32'(step_err),     32'(e.step_err));
                check("locked",       32'(locked),       32'(e.locked));
                check("err_count",    32'(err_count),    32'(e.err_count));
                check("err_small",    32'(s_err_count),  32'(e.err_small));
                check("small_locked", 32'(s_locked),     32'(e.locked));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] q;
        int r;
        logic [3:0] qs;

        // Reference sequence from an ideal Johnson shift register.
        q = '0;
        for (int k = 0; k < TWO_N; k++) begin
            seq[k] = q;
            q = {q[2:0], ~q[3]};
        end
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Acquire and lock, then run through the wrap.
        drive(1, 4'b0000, 0);
        drive(1, 4'b0001, 0);
        drive(1, 4'b0011, 0);
        drive(1, 4'b0111, 0);
        drive(1, 4'b1111, 0);
        drive(1, 4'b1110, 0);
        drive(1, 4'b1100, 0);
        drive(1, 4'b1000, 0);
        drive(1, 4'b0000, 0);

        // Locked at phase 2, then illegal code.
        drive(1, 4'b0001, 0);
        drive(1, 4'b0011, 0);
        drive(1, 4'b0101, 0);
        drive(1, 4'b0101, 0);

        // Relock ending at phase 1, then jump 1 -> 4, then relock.
        drive(1, 4'b1110, 0);
        drive(1, 4'b1100, 0);
        drive(1, 4'b1000, 0);
        drive(1, 4'b0000, 0);
        drive(1, 4'b0001, 0);
        drive(1, 4'b1111, 0);
        drive(1, 4'b1110, 0);
        drive(1, 4'b1100, 0);
        drive(1, 4'b1000, 0);

        // Hold off: outputs hold while q_in wanders.
        for (int i = 0; i < 3; i++) drive(0, 4'($urandom), 0);

        // Asynchronous reset between edges while locked.
        @(posedge clk);
        #2;
        check("pre_reset_locked", 32'(locked), 1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Five illegal codes: narrow counter saturates at 3, then clear wins.
        drive(1, 4'b0101, 0);
        drive(1, 4'b1010, 0);
        drive(1, 4'b1001, 0);
        drive(1, 4'b0110, 0);
        drive(1, 4'b1011, 0);
        drive(1, 4'b0100, 1);

        // Randomized traffic biased toward legal advances.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      qs = seq[(m_phase + 1) % TWO_N];
            else if (r < 65) qs = seq[m_phase];
            else if (r < 80) qs = seq[$urandom_range(0, TWO_N - 1)];
            else             qs = 4'($urandom);
            if ($urandom_range(0, 99) < 12) begin
                drive(0, qs, 0);
            end else begin
                drive(1, qs, ($urandom_range(0, 99) < 5));
            end
        end

        @(negedge clk);
        sample_en = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
